// File: rtl/unidade_controle.sv
// Command sequencer for the X/Y/Z register datapath.
// Drives register function codes and ALU select over one or more cycles.
module unidade_controle #(
  parameter int AMT_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  output logic [2:0]       tx,
  output logic [2:0]       ty,
  output logic [2:0]       tz,
  output logic             alu_sel,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] F_HOLD   = 3'b000;
  localparam logic [2:0] F_LOAD   = 3'b001;
  localparam logic [2:0] F_SHIFTR = 3'b010;
  localparam logic [2:0] F_SHIFTL = 3'b011;
  localparam logic [2:0] F_RESET  = 3'b100;

  localparam logic [2:0] OP_CLEAR = 3'b000;
  localparam logic [2:0] OP_LOADX = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_SHR   = 3'b100;
  localparam logic [2:0] OP_SHL   = 3'b101;
  localparam logic [2:0] OP_COPY  = 3'b110;
  localparam logic [2:0] OP_NOP   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP1,
    S_STEP2,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             alu_sel_q, alu_sel_d;

  // State and command registers; reset aborts any command in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= 3'b000;
      cnt_q     <= '0;
      alu_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      alu_sel_q <= alu_sel_d;
    end
  end

  // Next-state logic; command fields captured only on an accepted start
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    alu_sel_d = alu_sel_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d      = op;
          cnt_d     = amt;
          alu_sel_d = (op == OP_SUB);
          case (op)
            OP_SHR, OP_SHL:
              state_d = (amt != '0) ? S_SHIFT : S_DONE;
            OP_NOP:
              state_d = S_DONE;
            default:
              state_d = S_STEP1;
          endcase
        end
      end
      S_STEP1: begin
        if (op_q == OP_ADD || op_q == OP_SUB)
          state_d = S_STEP2;
        else
          state_d = S_DONE;
      end
      S_STEP2: state_d = S_DONE;
      S_SHIFT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= AMT_W'(1))
          state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from state and latched command only
  always_comb begin
    tx   = F_HOLD;
    ty   = F_HOLD;
    tz   = F_HOLD;
    busy = (state_q != S_IDLE);
    done = 1'b0;
    unique case (state_q)
      S_STEP1: begin
        case (op_q)
          OP_CLEAR: begin
            tx = F_RESET;
            ty = F_RESET;
            tz = F_RESET;
          end
          OP_LOADX:        tx = F_LOAD;
          OP_COPY:         tz = F_LOAD;
          OP_ADD, OP_SUB:  ty = F_LOAD;
          default: ;
        endcase
      end
      S_STEP2: tz = F_LOAD;
      S_SHIFT: tz = (op_q == OP_SHL) ? F_SHIFTL : F_SHIFTR;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign alu_sel = alu_sel_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle with a small X/Y/Z datapath
// model fed by the controller outputs.
module tb_unidade_controle;

  logic       clock;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [1:0] amt;
  logic [2:0] tx, ty, tz;
  logic       alu_sel, busy, done;

  logic [3:0] xin;
  logic [3:0] xr, yr, zr;

  int n_chk;
  int n_fail;

  unidade_controle #(.AMT_W(2)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .amt     (amt),
    .tx      (tx),
    .ty      (ty),
    .tz      (tz),
    .alu_sel (alu_sel),
    .busy    (busy),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register bank model: acts on codes present in the closing cycle,
  // shares the reset, which freezes it without clearing it.
  always @(posedge clock) begin
    if (!reset) begin
      case (tx)
        3'b001: xr <= xin;
        3'b100: xr <= 4'd0;
        default: ;
      endcase
      case (ty)
        3'b001: yr <= alu_sel ? (yr - xr) : (xr + yr);
        3'b100: yr <= 4'd0;
        default: ;
      endcase
      case (tz)
        3'b001: zr <= yr;
        3'b010: zr <= zr >> 1;
        3'b011: zr <= zr << 1;
        3'b100: zr <= 4'd0;
        default: ;
      endcase
    end
  end

  task automatic check(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [1:0] a);
    start = 1'b1;
    op    = o;
    amt   = a;
    step();
    start = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [2:0] ex,
                         input logic [2:0] ey, input logic [2:0] ez,
                         input logic eb, input logic ed);
    check({tag, ".tx"}, {5'd0, tx}, {5'd0, ex});
    check({tag, ".ty"}, {5'd0, ty}, {5'd0, ey});
    check({tag, ".tz"}, {5'd0, tz}, {5'd0, ez});
    check({tag, ".busy"}, {7'd0, busy}, {7'd0, eb});
    check({tag, ".done"}, {7'd0, done}, {7'd0, ed});
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    start  = 1'b1;
    op     = 3'b000;
    amt    = 2'd0;
    xin    = 4'd0;

    // reset dominates start
    step();
    chk_out("rst1", 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    step();
    chk_out("rst2", 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    check("rst.alu_sel", {7'd0, alu_sel}, 8'd0);
    start = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out("idle", 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    end

    // CLEAR: one cycle of RESET codes then done
    issue(3'b000, 2'd0);
    chk_out("clr.s1", 3'd4, 3'd4, 3'd4, 1'b1, 1'b0);
    step();
    chk_out("clr.dn", 3'd0, 3'd0, 3'd0, 1'b1, 1'b1);
    check("clr.x", {4'd0, xr}, 8'd0);
    check("clr.z", {4'd0, zr}, 8'd0);
    step();
    chk_out("clr.id", 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);

    // NOP: done straight away
    issue(3'b111, 2'd0);
    chk_out("nop.dn", 3'd0, 3'd0, 3'd0, 1'b1, 1'b1);
    step();
    chk_out("nop.id", 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);

    // LOADX 4, ADD -> Y=4, Z=4
    xin = 4'd4;
    issue(3'b001, 2'd0);
    chk_out("ldx.s1", 3'd1, 3'd0, 3'd0, 1'b1, 1'b0);
    step();
    check("ldx.done", {7'd0, done}, 8'd1);
    check("ldx.x", {4'd0, xr}, 8'd4);
    step();
    issue(3'b010, 2'd0);
    chk_out("add1.s1", 3'd0, 3'd1, 3'd0, 1'b1, 1'b0);
    check("add1.alu", {7'd0, alu_sel}, 8'd0);
    step();
    chk_out("add1.s2", 3'd0, 3'd0, 3'd1, 1'b1, 1'b0);
    check("add1.y", {4'd0, yr}, 8'd4);
    step();
    chk_out("add1.dn", 3'd0, 3'd0, 3'd0, 1'b1, 1'b1);
    check("add1.z", {4'd0, zr}, 8'd4);
    step();

    // LOADX 3, ADD -> 3+4 = 7
    xin = 4'd3;
    issue(3'b001, 2'd0);
    step();
    step();
    issue(3'b010, 2'd0);
    check("add2.ty", {5'd0, ty}, 8'd1);
    step();
    check("add2.tz", {5'd0, tz}, 8'd1);
    step();
    check("add2.done", {7'd0, done}, 8'd1);
    check("add2.z", {4'd0, zr}, 8'd7);
    step();

    // Z = 1: CLEAR, LOADX 1, ADD
    issue(3'b000, 2'd0);
    step();
    step();
    xin = 4'd1;
    issue(3'b001, 2'd0);
    step();
    step();
    issue(3'b010, 2'd0);
    step();
    step();
    check("z1", {4'd0, zr}, 8'd1);
    step();

    // SHL by 3: SHIFTL for exactly three cycles
    issue(3'b101, 2'd3);
    for (int i = 0; i < 3; i++) begin
      chk_out("shl.sh", 3'd0, 3'd0, 3'd3, 1'b1, 1'b0);
      step();
    end
    chk_out("shl.dn", 3'd0, 3'd0, 3'd0, 1'b1, 1'b1);
    check("shl.z", {4'd0, zr}, 8'd8);
    step();

    // SHL by 0: no shift issued
    issue(3'b101, 2'd0);
    chk_out("shl0.dn", 3'd0, 3'd0, 3'd0, 1'b1, 1'b1);
    step();
    chk_out("shl0.id", 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    check("shl0.z", {4'd0, zr}, 8'd8);

    // SUB with starts during STEP2 and DONE (X=1, Y=1)
    issue(3'b011, 2'd0);
    chk_out("sub.s1", 3'd0, 3'd1, 3'd0, 1'b1, 1'b0);
    check("sub.alu", {7'd0, alu_sel}, 8'd1);
    start = 1'b1;
    op    = 3'b000;
    step();
    chk_out("sub.s2", 3'd0, 3'd0, 3'd1, 1'b1, 1'b0);
    check("sub.alu2", {7'd0, alu_sel}, 8'd1);
    step();
    chk_out("sub.dn", 3'd0, 3'd0, 3'd0, 1'b1, 1'b1);
    step();
    start = 1'b0;
    chk_out("sub.id", 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    check("sub.alu3", {7'd0, alu_sel}, 8'd1);
    check("sub.x", {4'd0, xr}, 8'd1);
    check("sub.y", {4'd0, yr}, 8'd0);
    step();
    chk_out("sub.id2", 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);

    // Z = 4: LOADX 4, ADD (Y = 4 + 0)
    xin = 4'd4;
    issue(3'b001, 2'd0);
    step();
    step();
    issue(3'b010, 2'd0);
    step();
    step();
    step();
    check("z4", {4'd0, zr}, 8'd4);

    // SHR by 3 with reset in the second shift cycle
    issue(3'b100, 2'd3);
    chk_out("shr.sh1", 3'd0, 3'd0, 3'd2, 1'b1, 1'b0);
    step();
    chk_out("shr.sh2", 3'd0, 3'd0, 3'd2, 1'b1, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_out("shr.rst", 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    check("shr.alu", {7'd0, alu_sel}, 8'd0);
    check("shr.z", {4'd0, zr}, 8'd2);
    step();
    chk_out("shr.id", 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);

    // SHR by 1 after the abort
    issue(3'b100, 2'd1);
    chk_out("shr1.sh", 3'd0, 3'd0, 3'd2, 1'b1, 1'b0);
    step();
    chk_out("shr1.dn", 3'd0, 3'd0, 3'd0, 1'b1, 1'b1);
    check("shr1.z", {4'd0, zr}, 8'd1);

    // COPY: Z <- Y (Y = 4)
    step();
    issue(3'b110, 2'd0);
    chk_out("cpy.s1", 3'd0, 3'd0, 3'd1, 1'b1, 1'b0);
    step();
    chk_out("cpy.dn", 3'd0, 3'd0, 3'd0, 1'b1, 1'b1);
    check("cpy.z", {4'd0, zr}, 8'd4);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Sequencing controller for the X/Y/Z register datapath: accepts one command per start pulse and drives the 3-bit function codes of registers X, Y and Z, plus the ALU operation select, over one or more cycles. It sits directly upstream of the register bank; its `tz` output is the `func` input of register Z, whose `outY` input is fed by register Y. It reports `busy` while a command executes and a one-cycle `done` pulse on completion.

## Interface
- `AMT_W`, default 2: width of the shift-amount input; maximum shift count is 2^AMT_W − 1.
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  command request; sampled only in IDLE.
- `op`  in  3  command code, captured with `start`.
- `amt`  in  AMT_W  shift count for SHR/SHL, captured with `start`.
- `tx`, `ty`, `tz`  out  3 each  function codes for registers X, Y, Z.
- `alu_sel`  out  1  ALU operation: 0 = X+Y, 1 = Y−X.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Function codes must match the register encoding: HOLD 000, LOAD 001, SHIFTR 010, SHIFTL 011, RESET 100. Any function output not listed for a state is HOLD.
- Commands: 000 CLEAR (X, Y and Z to 0); 001 LOADX (X ← external input); 010 ADD (Y ← X+Y, then Z ← Y); 011 SUB (Y ← Y−X, then Z ← Y); 100 SHR (Z >> 1, repeated `amt` times); 101 SHL (Z << 1, repeated `amt` times); 110 COPY (Z ← Y); 111 NOP.
- `op_r`, `cnt` and `alu_sel` are registers. `op_r` and `cnt` load from `op`/`amt` only on an accepted start.
- States and transitions:
  - IDLE: outputs all HOLD, `busy`=0, `done`=0.
    - `start`=1 with CLEAR, LOADX, COPY, ADD or SUB → STEP1.
    - `start`=1 with SHR or SHL: `amt`≠0 → SHIFT; `amt`=0 → DONE.
    - `start`=1 with NOP → DONE.
  - STEP1:
    - CLEAR: `tx`=`ty`=`tz`=RESET.
    - LOADX: `tx`=LOAD.
    - COPY: `tz`=LOAD.
    - ADD/SUB: `ty`=LOAD.
    - Next state: STEP2 for ADD/SUB, otherwise DONE.
  - STEP2 (ADD/SUB only): `tz`=LOAD → DONE.
  - SHIFT: `tz`=SHIFTR (SHR) or SHIFTL (SHL); `cnt` decrements each cycle; when `cnt`=1, next state is DONE.
  - DONE: all HOLD, `done`=1 → IDLE.
- `alu_sel` is set on an accepted start (1 for SUB, 0 for all other commands) and holds until the next accepted start. It is therefore stable through STEP1 and STEP2.
- `start` outside IDLE (including in DONE) is ignored; it is not queued.
- Unused encodings never appear on `tx`/`ty`/`tz`.

## Timing
- Reset: at the first rising edge with `reset`=1:
  - state → IDLE; `tx`=`ty`=`tz`=000; `alu_sel`=0; `busy`=0; `done`=0; `op_r`=0; `cnt`=0.
  - `reset` dominates `start`.
- Reset mid-command aborts at that edge. No RESET code is issued to the registers, so they keep their contents.
- Outputs are Moore (a function of state and `op_r` only); no combinational path from `start`/`op` to any output.
- A function code is asserted for the entire cycle it is present; the register acts at the edge that closes that cycle.
- With `start` sampled at edge 0, latency from edge 0 to the `done` cycle:
  - CLEAR, LOADX, COPY: 2 cycles (STEP1, then DONE).
  - ADD, SUB: 3 cycles (STEP1, STEP2, then DONE).
  - SHR/SHL with amt=n≥1: n+1 cycles.
  - NOP, or SHR/SHL with amt=0: 1 cycle (DONE directly).
- Earliest next accept: the edge after DONE, i.e. back-to-back commands leave exactly one IDLE cycle between `done` and the next STEP1/SHIFT.

## Test plan
- Reset then idle: hold `reset`=1 for 2 cycles, then `start`=0 for 5 cycles → `tx`/`ty`/`tz`=000, `busy`=0 and `done`=0 every cycle.
- ADD: `start`=1, op=010 for one cycle → next cycle `ty`=001 with `alu_sel`=0, then `tz`=001, then `done`=1; `busy`=1 for 3 cycles. With X=3, Y=4 the downstream Z reads 7.
- SHL count: Z=0001, op=101, amt=3 → `tz`=011 for exactly 3 cycles, then `done`; Z=1000. Repeat with amt=0 → `done` the cycle after start and no SHIFTL issued.
- Start while busy: issue SUB, then pulse `start` with op=000 during STEP2 and again during DONE → both ignored; no RESET codes appear; exactly one `done` pulse.
- Mid-op reset: SHR with amt=3, assert `reset` during the 2nd SHIFT cycle → next cycle IDLE with all HOLD; Z shows exactly one completed shift and no `done` pulse.
- CLEAR, then NOP: CLEAR → one cycle with `tx`=`ty`=`tz`=100, then `done`. NOP (op=111) → `done` the cycle after start with all outputs HOLD.
